// File: rtl/fractran_pkg.sv
// Shared types and lane-slicing helpers for the FRACTRAN exponent-vector engine.
package fractran_pkg;

  localparam int NPRIME_DEF = 4;
  localparam int EXP_W_DEF  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_PAUSE,
    S_HALT,
    S_FAULT
  } state_t;

  // Lane k of a packed exponent vector starts at bit k*w.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fractran_lane_alu.sv
// One prime lane: divisibility test (acc >= den) and acc - den + num with carry-out.
module fractran_lane_alu #(
  parameter int EXP_W = 4
) (
  input  logic [EXP_W-1:0] acc,
  input  logic [EXP_W-1:0] num,
  input  logic [EXP_W-1:0] den,
  output logic             ge,
  output logic [EXP_W-1:0] res,
  output logic             ovf
);

  logic [EXP_W:0] wide;

  assign ge   = (acc >= den);
  // Only meaningful when ge=1; then acc-den >= 0 and the sum fits in EXP_W+1 bits.
  assign wide = {1'b0, acc} - {1'b0, den} + {1'b0, num};
  assign res  = wide[EXP_W-1:0];
  assign ovf  = wide[EXP_W];

endmodule

// File: rtl/fractran_engine.sv
// FRACTRAN interpreter over prime-exponent vectors: scans one program slot per cycle,
// applies the first fraction whose denominator divides the accumulator.
module fractran_engine
  import fractran_pkg::*;
#(
  parameter  int NPRIME = NPRIME_DEF,
  parameter  int EXP_W  = EXP_W_DEF,
  parameter  int DEPTH  = 8,
  parameter  int CNT_W  = 8,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int VW     = NPRIME * EXP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [VW-1:0]    prog_num,
  input  logic [VW-1:0]    prog_den,
  input  logic [AW:0]      prog_len,
  input  logic [VW-1:0]    acc_in,
  input  logic             start,
  input  logic             abort,
  input  logic             single,
  input  logic             step,
  output logic [VW-1:0]    acc_out,
  output logic [CNT_W-1:0] steps,
  output logic             busy,
  output logic             paused,
  output logic             halt,
  output logic             fault,
  output logic             limit
);

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  state_t            state, state_n;
  logic [VW-1:0]     acc, acc_n;
  logic [CNT_W-1:0]  steps_n, steps_inc;
  logic [AW-1:0]     idx, idx_n;
  logic [AW:0]       len, len_n, len_in;
  logic              single_r, single_n;
  logic              halt_n, fault_n, limit_n;

  logic [VW-1:0]     num_mem [DEPTH];
  logic [VW-1:0]     den_mem [DEPTH];
  logic [VW-1:0]     num_rd, den_rd, res_v;
  logic [NPRIME-1:0] ge_v, ovf_v;
  logic              hit, any_ovf, last;

  assign busy    = (state == S_SCAN) || (state == S_PAUSE);
  assign paused  = (state == S_PAUSE);
  assign acc_out = acc;

  // Program store: data only, never reset; frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (prog_we && !busy && ({1'b0, prog_addr} < DEPTH_V)) begin
      num_mem[prog_addr] <= prog_num;
      den_mem[prog_addr] <= prog_den;
    end
  end

  assign num_rd = num_mem[idx];
  assign den_rd = den_mem[idx];

  for (genvar k = 0; k < NPRIME; k++) begin : g_lane
    localparam int LO = lane_lo(k, EXP_W);
    fractran_lane_alu #(.EXP_W(EXP_W)) u_alu (
      .acc (acc[LO +: EXP_W]),
      .num (num_rd[LO +: EXP_W]),
      .den (den_rd[LO +: EXP_W]),
      .ge  (ge_v[k]),
      .res (res_v[LO +: EXP_W]),
      .ovf (ovf_v[k])
    );
  end

  assign hit       = &ge_v;
  assign any_ovf   = |ovf_v;
  assign steps_inc = steps + 1'b1;
  assign last      = ({1'b0, idx} == (len - 1'b1));
  assign len_in    = (prog_len > DEPTH_V) ? DEPTH_V : prog_len;

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    steps_n  = steps;
    idx_n    = idx;
    len_n    = len;
    single_n = single_r;
    halt_n   = halt;
    fault_n  = fault;
    limit_n  = limit;
    unique case (state)
      S_SCAN: begin
        if (abort) begin
          state_n = S_IDLE;
          halt_n  = 1'b0;
          fault_n = 1'b0;
          limit_n = 1'b0;
        end else if (len == '0) begin
          halt_n  = 1'b1;
          state_n = S_HALT;
        end else if (hit) begin
          if (any_ovf) begin
            fault_n = 1'b1;
            state_n = S_FAULT;
          end else begin
            acc_n   = res_v;
            steps_n = steps_inc;
            idx_n   = '0;
            // Saturating step count: stop rather than wrap.
            if (&steps_inc) begin
              limit_n = 1'b1;
              halt_n  = 1'b1;
              state_n = S_HALT;
            end else if (single_r) begin
              state_n = S_PAUSE;
            end
          end
        end else if (last) begin
          halt_n  = 1'b1;
          state_n = S_HALT;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      S_PAUSE: begin
        if (abort) begin
          state_n = S_IDLE;
          halt_n  = 1'b0;
          fault_n = 1'b0;
          limit_n = 1'b0;
        end else if (step) begin
          state_n = S_SCAN;
        end
      end
      default: begin
        if (start) begin
          acc_n    = acc_in;
          steps_n  = '0;
          idx_n    = '0;
          len_n    = len_in;
          single_n = single;
          halt_n   = 1'b0;
          fault_n  = 1'b0;
          limit_n  = 1'b0;
          state_n  = S_SCAN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      steps    <= '0;
      idx      <= '0;
      len      <= '0;
      single_r <= 1'b0;
      halt     <= 1'b0;
      fault    <= 1'b0;
      limit    <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      steps    <= steps_n;
      idx      <= idx_n;
      len      <= len_n;
      single_r <= single_n;
      halt     <= halt_n;
      fault    <= fault_n;
      limit    <= limit_n;
    end
  end

endmodule

// File: tb/tb_fractran_engine.sv
// Self-checking bench for fractran_engine: directed FRACTRAN programs plus randomized runs
// compared every cycle against a step-level behavioural model.
module tb_fractran_engine;

  localparam int NP = 4;
  localparam int EW = 4;
  localparam int DP = 8;

  logic        clk = 1'b0;
  logic        rst_n, prog_we, start, abort, single, step;
  logic [2:0]  prog_addr;
  logic [15:0] prog_num, prog_den, acc_in;
  logic [3:0]  prog_len;

  logic [15:0] acc_out, acc_out2;
  logic [7:0]  steps;
  logic [1:0]  steps2;
  logic        busy, paused, halt, fault, limit;
  logic        busy2, paused2, halt2, fault2, limit2;

  fractran_engine #(.NPRIME(NP), .EXP_W(EW), .DEPTH(DP), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_num(prog_num), .prog_den(prog_den), .prog_len(prog_len), .acc_in(acc_in),
    .start(start), .abort(abort), .single(single), .step(step),
    .acc_out(acc_out), .steps(steps), .busy(busy), .paused(paused),
    .halt(halt), .fault(fault), .limit(limit)
  );

  fractran_engine #(.NPRIME(NP), .EXP_W(EW), .DEPTH(DP), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_num(prog_num), .prog_den(prog_den), .prog_len(prog_len), .acc_in(acc_in),
    .start(start), .abort(abort), .single(single), .step(step),
    .acc_out(acc_out2), .steps(steps2), .busy(busy2), .paused(paused2),
    .halt(halt2), .fault(fault2), .limit(limit2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ev(input int a, input int b, input int c, input int d);
    return {d[3:0], c[3:0], b[3:0], a[3:0]};
  endfunction

  // Behavioural model: mode 0 = not running, 1 = searching, 2 = paused.
  int mnum [DP][NP];
  int mden [DP][NP];
  int macc [NP];
  int msteps = 0, mmode = 0, mlen = 0, mcnt = 0, mslot = -1;
  bit mhalt = 0, mfault = 0, mlimit = 0, msingle = 0;

  function automatic logic [15:0] pack_m();
    logic [15:0] v;
    for (int k = 0; k < NP; k++) v[k*EW +: EW] = macc[k][3:0];
    return v;
  endfunction

  // Decide the outcome of the next search and how many cycles it takes.
  function automatic void plan();
    mslot = -1;
    for (int s = 0; s < mlen && mslot < 0; s++) begin
      bit ok = 1'b1;
      for (int k = 0; k < NP; k++) if (macc[k] < mden[s][k]) ok = 1'b0;
      if (ok) mslot = s;
    end
    if (mslot >= 0) mcnt = mslot + 1;
    else mcnt = (mlen == 0) ? 1 : mlen;
  endfunction

  function automatic void resolve();
    int nw [NP];
    bit ov = 1'b0;
    if (mslot < 0) begin
      mhalt = 1'b1; mmode = 0;
      return;
    end
    for (int k = 0; k < NP; k++) begin
      nw[k] = macc[k] - mden[mslot][k] + mnum[mslot][k];
      if (nw[k] > 15) ov = 1'b1;
    end
    if (ov) begin
      mfault = 1'b1; mmode = 0;
    end else begin
      macc = nw;
      msteps++;
      if (msteps == 255) begin
        mlimit = 1'b1; mhalt = 1'b1; mmode = 0;
      end else if (msingle) mmode = 2;
      else plan();
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NP; k++) macc[k] = 0;
      msteps = 0; mmode = 0; mhalt = 0; mfault = 0; mlimit = 0;
    end else begin
      if (prog_we && mmode == 0)
        for (int k = 0; k < NP; k++) begin
          mnum[prog_addr][k] = int'(prog_num[k*EW +: EW]);
          mden[prog_addr][k] = int'(prog_den[k*EW +: EW]);
        end
      case (mmode)
        0: if (start) begin
          for (int k = 0; k < NP; k++) macc[k] = int'(acc_in[k*EW +: EW]);
          msteps = 0; mhalt = 0; mfault = 0; mlimit = 0;
          mlen = (prog_len > 8) ? 8 : int'(prog_len);
          msingle = single;
          mmode = 1;
          plan();
        end
        1: if (abort) begin
          mmode = 0; mhalt = 0; mfault = 0; mlimit = 0;
        end else begin
          mcnt--;
          if (mcnt == 0) resolve();
        end
        default: if (abort) begin
          mmode = 0; mhalt = 0; mfault = 0; mlimit = 0;
        end else if (step) begin
          mmode = 1;
          plan();
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_acc", acc_out, pack_m());
      check("cyc_steps", steps, msteps);
      check("cyc_flags", {busy, paused, halt, fault, limit},
            {mmode != 0, mmode == 2, mhalt, mfault, mlimit});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_slot(input int a, input logic [15:0] n, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a[2:0]; prog_num = n; prog_den = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_start(input int len, input logic [15:0] a, input bit sgl);
    prog_len = len[3:0]; acc_in = a; single = sgl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic settle(input string nm, input int budget);
    int n = 0;
    while (busy && !paused && n < budget) begin
      tick();
      n++;
    end
    check(nm, (busy && !paused), 1'b0);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_num = '0; prog_den = '0;
    prog_len = '0; acc_in = '0; start = 1'b0; abort = 1'b0; single = 1'b0; step = 1'b0;
    repeat (2) tick();
    check("reset_acc", acc_out, 16'h0000);
    check("reset_steps", steps, 8'd0);
    check("reset_flags", {busy, paused, halt, fault, limit}, 5'b0);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;
    for (int s = 0; s < DP; s++) load_slot(s, 16'h0000, 16'hFFFF);

    // 2^3 under {3/2}
    load_slot(0, ev(0, 1, 0, 0), ev(1, 0, 0, 0));
    do_start(1, ev(3, 0, 0, 0), 1'b0);
    cyc = 1;
    while (!halt && cyc < 20) begin
      tick();
      cyc++;
    end
    check("t033_cycles", cyc, 5);
    check("t033_acc", acc_out, ev(0, 3, 0, 0));
    check("t033_steps", steps, 3);

    // [7/3, 5/2] from 2*3, observed step by step
    load_slot(0, ev(0, 0, 0, 1), ev(0, 1, 0, 0));
    load_slot(1, ev(0, 0, 1, 0), ev(1, 0, 0, 0));
    do_start(2, ev(1, 1, 0, 0), 1'b1);
    settle("t034_wait1", 50);
    check("t034_acc1", acc_out, ev(1, 0, 0, 1));
    pulse_step();
    settle("t034_wait2", 50);
    check("t034_acc2", acc_out, ev(0, 0, 1, 1));
    pulse_step();
    settle("t034_wait3", 50);
    check("t034_end", {halt, steps}, {1'b1, 8'd2});

    // exponent overflow
    load_slot(0, ev(0, 1, 0, 0), 16'h0000);
    do_start(1, ev(0, 15, 0, 0), 1'b0);
    settle("t035_wait", 50);
    check("t035_fault", {fault, halt}, 2'b10);
    check("t035_acc", acc_out, ev(0, 15, 0, 0));
    check("t035_steps", steps, 0);

    // single-step {3/2} from 2^2
    load_slot(0, ev(0, 1, 0, 0), ev(1, 0, 0, 0));
    do_start(1, ev(2, 0, 0, 0), 1'b1);
    settle("t036_wait1", 50);
    check("t036_p1", {paused, acc_out}, {1'b1, ev(1, 1, 0, 0)});
    pulse_step();
    settle("t036_wait2", 50);
    check("t036_p2", {paused, acc_out}, {1'b1, ev(0, 2, 0, 0)});
    pulse_step();
    settle("t036_wait3", 50);
    check("t036_halt", {halt, busy}, 2'b10);

    // {2/1} from 1: 2-bit counter saturates, wide counter runs to overflow
    load_slot(0, ev(1, 0, 0, 0), 16'h0000);
    do_start(1, 16'h0000, 1'b0);
    settle("t037_wait", 50);
    check("t037_c2_flags", {limit2, halt2, fault2}, 3'b110);
    check("t037_c2_steps", steps2, 2'd3);
    check("t037_c2_acc", acc_out2, ev(3, 0, 0, 0));
    check("t037_c8_end", {fault, steps}, {1'b1, 8'd15});

    // abort mid-run keeps acc/steps
    do_start(1, 16'h0000, 1'b0);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t038_abort", {busy, halt, steps, acc_out}, {1'b0, 1'b0, 8'd3, ev(3, 0, 0, 0)});

    // reset mid-run clears everything
    do_start(1, 16'h0000, 1'b0);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check("t038_reset", {busy, steps, acc_out}, 25'h0);
    rst_n = 1'b1;
    tick();

    // empty program
    do_start(0, ev(1, 2, 3, 4), 1'b0);
    settle("len0_wait", 20);
    check("len0_end", {halt, steps, acc_out}, {1'b1, 8'd0, ev(1, 2, 3, 4)});

    // [3/2, 2/3] loops forever until the 8-bit counter saturates
    load_slot(0, ev(0, 1, 0, 0), ev(1, 0, 0, 0));
    load_slot(1, ev(1, 0, 0, 0), ev(0, 1, 0, 0));
    do_start(2, ev(1, 0, 0, 0), 1'b0);
    settle("lim_wait", 1000);
    check("lim_end", {limit, halt, steps}, {1'b1, 1'b1, 8'd255});

    // randomized programs, lengths (incl. > DEPTH), single-step, aborts, ignored writes/starts
    for (int r = 0; r < 18; r++) begin
      int n;
      for (int s = 0; s < DP; s++)
        load_slot(s, ev($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1)),
                  ev($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1)));
      do_start($urandom_range(0, 15),
               ev($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
               ($urandom_range(0, 2) == 0));
      n = 0;
      while (busy && n < 3000) begin
        step    = paused && ($urandom_range(0, 2) == 0);
        abort   = ($urandom_range(0, 299) == 0);
        start   = ($urandom_range(0, 19) == 0);
        prog_we = ($urandom_range(0, 9) == 0);
        prog_addr = 3'($urandom_range(0, 7));
        prog_num  = 16'($urandom);
        prog_den  = 16'($urandom);
        tick();
        n++;
      end
      step = 1'b0; abort = 1'b0; start = 1'b0; prog_we = 1'b0;
      check("rand_done", busy, 1'b0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fractran_engine.md
FRACTRAN_ENGINE -- requirements
Module: fractran_engine

Interface
REQ-001 Parameter NPRIME, 4, number of prime exponent lanes (lane k = k-th prime: 2,3,5,7,...).
REQ-002 Parameter EXP_W, 4, bits per exponent lane.
REQ-003 Parameter DEPTH, 8, fraction program slots; AW = clog2(DEPTH).
REQ-004 Parameter CNT_W, 8, step counter width.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 prog_we  in  1  write program slot prog_addr with prog_num/prog_den.
REQ-008 prog_addr  in  AW; prog_num, prog_den  in  NPRIME*EXP_W  exponent vectors (lane k at bits k*EXP_W +: EXP_W).
REQ-009 prog_len  in  AW+1  active fraction count, sampled at start.
REQ-010 acc_in  in  NPRIME*EXP_W  initial accumulator exponents, sampled at start.
REQ-011 start  in  1  begin run; abort  in  1  cancel run.
REQ-012 single  in  1  single-step mode, sampled at start; step  in  1  advance one step when paused.
REQ-013 acc_out  out  NPRIME*EXP_W  current accumulator; steps  out  CNT_W  applied-fraction count.
REQ-014 busy, paused, halt, fault, limit  out  1 each  status flags.

Function
REQ-015 States IDLE, SCAN, PAUSE, HALT, FAULT; busy=1 in SCAN and PAUSE only; paused=1 in PAUSE only.
REQ-016 IDLE/HALT/FAULT + start: acc<=acc_in, steps<=0, idx<=0, halt/fault/limit<=0, -> SCAN next cycle.
REQ-017 SCAN tests exactly one slot per cycle: slot idx matches iff acc[k] >= den[k] for every lane k.
REQ-018 Match: acc[k] <= acc[k] - den[k] + num[k] in (EXP_W+1)-bit arithmetic, steps++, idx<=0, same edge.
REQ-019 Match with any lane result > 2^EXP_W-1: acc unchanged, steps unchanged, fault<=1, -> FAULT.
REQ-020 No match and idx < prog_len-1: idx++; no match and idx == prog_len-1: halt<=1, -> HALT.
REQ-021 prog_len == 0: first SCAN cycle -> HALT, acc = acc_in, steps = 0.
REQ-022 prog_len > DEPTH is clamped to DEPTH.
REQ-023 Step cost: k+1 cycles when slot k is the first match; lower index wins when several match.
REQ-024 Successful step leaving steps == 2^CNT_W-1: limit<=1, halt<=1, -> HALT (no wrap).
REQ-025 single=1: after each successful step -> PAUSE; PAUSE + step -> SCAN next cycle.
REQ-026 abort in SCAN or PAUSE: -> IDLE next cycle, acc/steps retained, flags cleared; abort wins over start, step and a same-cycle match (no update).
REQ-027 start while busy ignored; prog_we while busy ignored; prog_we with prog_addr >= DEPTH ignored.
REQ-028 halt, fault, limit hold until next start or reset.

Reset
REQ-029 rst_n=0 at clk edge: state IDLE, acc_out=0, steps=0, idx=0, all status flags 0.
REQ-030 Reset mid-run overrides all inputs; program memory contents not cleared (undefined after power-up).

Structure
REQ-031 Package fractran_pkg holds state enum and lane-slicing helper constants; NPRIME/EXP_W defaults defined there.
REQ-032 One sub-module fractran_lane_alu (per-lane >= compare, subtract/add, overflow bit), instantiated NPRIME times.

Verification
REQ-033 Prog {3/2} (num lane1=1, den lane0=1), len 1, acc 2^3 -> HALT, acc 3^3, steps=3, start-to-halt 5 cycles.
REQ-034 Prog [7/3, 5/2], acc 2*3 -> first step applies 7/3 (acc 2*7), second 5/2 (acc 5*7), then HALT, steps=2.
REQ-035 EXP_W=4, prog {3/1}, acc 3^15 -> FAULT, fault=1, acc 3^15, steps=0.
REQ-036 single=1, prog {3/2}, acc 2^2 -> PAUSE after step 1 (acc 2*3); step pulse -> PAUSE (acc 3^2); step -> HALT.
REQ-037 CNT_W=2, prog {2/1}, acc 1 -> limit=1, halt=1, steps=3, acc 2^3.
REQ-038 rst_n=0 mid-SCAN -> next cycle IDLE, acc_out 0, steps 0; abort mid-SCAN -> IDLE, acc/steps retained.
